alu_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle registered ALU. It accepts one operation per cycle over a valid/ready handshake, computes it combinationally at the input, and carries the result through `Stages` register slices with full backpressure support. It adds XOR and shift operations, a zero flag and configurable depth. It sits between an operand-fetch stage and a result sink that may stall.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_pipe_slice.sv | 43 ++++
 rtl/alu_pipe.sv | 90 +++++++++
 tb/tb_alu_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and result-flag layout for the pipelined ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_SRA = 3'd7
  } opc_t;

  localparam logic [2:0] OPC_ADD = 3'd0;
  localparam logic [2:0] OPC_SUB = 3'd1;
  localparam logic [2:0] OPC_AND = 3'd2;
  localparam logic [2:0] OPC_OR  = 3'd3;
  localparam logic [2:0] OPC_XOR = 3'd4;
  localparam logic [2:0] OPC_SHL = 3'd5;
  localparam logic [2:0] OPC_SHR = 3'd6;
  localparam logic [2:0] OPC_SRA = 3'd7;

  // Flags sit in the low bits of every slice payload, below the result.
  typedef struct packed {
    logic ovf;
    logic zero;
  } flags_t;

  localparam int FLAG_W = $bits(flags_t);

  function automatic flags_t make_flags(input logic ovf, input logic zero);
    flags_t f;
    f.ovf  = ovf;
    f.zero = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_pipe_slice.sv
// One valid/ready register slice; accepts whenever empty or draining downstream.
module alu_pipe_slice #(
  parameter int PW = 10
) (
  input  logic          Clk_i,
  input  logic          Reset_i,
  input  logic          Valid_i,
  output logic          Ready_o,
  input  logic [PW-1:0] Data_i,
  output logic          Valid_o,
  input  logic          Ready_i,
  output logic [PW-1:0] Data_o
);

  logic          vld_q, vld_d;
  logic [PW-1:0] data_q, data_d;

  assign Ready_o = !vld_q || Ready_i;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (Ready_o) begin
      vld_d = Valid_i;
      if (Valid_i) data_d = Data_i;
    end
  end

  // Payload is cleared too so that outputs read zero straight out of reset.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign Valid_o = vld_q;
  assign Data_o  = data_q;

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: combinational compute at the input, then Stages elastic slices.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int Width  = 8,
  parameter int Stages = 2
) (
  input  logic             Clk_i,
  input  logic             Reset_i,
  input  logic             Valid_i,
  output logic             Ready_o,
  input  logic [2:0]       Opc_i,
  input  logic [Width-1:0] DinA_i,
  input  logic [Width-1:0] DinB_i,
  output logic             Valid_o,
  input  logic             Ready_i,
  output logic [Width-1:0] Dout_o,
  output logic             OverFlow_o,
  output logic             Zero_o
);

  localparam int ShW = $clog2(Width);
  localparam int PW  = Width + FLAG_W;

  logic        [Width:0]   sum_w, diff_w;
  logic        [ShW-1:0]   sh_amt;
  logic signed [Width-1:0] a_s;
  logic        [Width-1:0] res_p0;
  logic                    ovf_p0;
  opc_t                    opc;

  assign sum_w  = {1'b0, DinA_i} + {1'b0, DinB_i};
  assign diff_w = {1'b0, DinA_i} - {1'b0, DinB_i};
  assign sh_amt = DinB_i[ShW-1:0];
  assign a_s    = DinA_i;
  assign opc    = opc_t'(Opc_i);

  always_comb begin
    res_p0 = '0;
    ovf_p0 = 1'b0;
    case (opc)
      OP_ADD: begin
        res_p0 = sum_w[Width-1:0];
        ovf_p0 = sum_w[Width];
      end
      OP_SUB: begin
        res_p0 = diff_w[Width-1:0];
        ovf_p0 = diff_w[Width];
      end
      OP_AND: res_p0 = DinA_i & DinB_i;
      OP_OR:  res_p0 = DinA_i | DinB_i;
      OP_XOR: res_p0 = DinA_i ^ DinB_i;
      OP_SHL: res_p0 = DinA_i << sh_amt;
      OP_SHR: res_p0 = DinA_i >> sh_amt;
      OP_SRA: res_p0 = a_s >>> sh_amt;
      default: res_p0 = '0;
    endcase
  end

  // ---- slice chain: index 0 is the compute output, index Stages the block output
  logic [Stages:0] vld, rdy;
  logic [PW-1:0]   pl [Stages+1];

  assign vld[0]      = Valid_i;
  assign pl[0]       = {res_p0, make_flags(ovf_p0, res_p0 == '0)};
  assign rdy[Stages] = Ready_i;
  assign Ready_o     = rdy[0];

  for (genvar k = 0; k < Stages; k++) begin : g_slice
    alu_pipe_slice #(.PW(PW)) u_slice (
      .Clk_i   (Clk_i),
      .Reset_i (Reset_i),
      .Valid_i (vld[k]),
      .Ready_o (rdy[k]),
      .Data_i  (pl[k]),
      .Valid_o (vld[k+1]),
      .Ready_i (rdy[k+1]),
      .Data_o  (pl[k+1])
    );
  end

  flags_t flg_o;

  assign flg_o      = pl[Stages][FLAG_W-1:0];
  assign Valid_o    = vld[Stages];
  assign Dout_o     = pl[Stages][PW-1:FLAG_W];
  assign OverFlow_o = flg_o.ovf;
  assign Zero_o     = flg_o.zero;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (Width=8, Stages=2) with a queue-based reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  logic       Clk_i = 1'b0;
  logic       Reset_i = 1'b1;
  logic       Valid_i = 1'b0;
  logic       Ready_o;
  logic [2:0] Opc_i = 3'd0;
  logic [7:0] DinA_i = 8'd0;
  logic [7:0] DinB_i = 8'd0;
  logic       Valid_o;
  logic       Ready_i = 1'b1;
  logic [7:0] Dout_o;
  logic       OverFlow_o;
  logic       Zero_o;

  int n_cmp = 0;
  int n_fail = 0;
  logic [9:0] q[$];

  alu_pipe #(.Width(8), .Stages(2)) dut (
    .Clk_i      (Clk_i),
    .Reset_i    (Reset_i),
    .Valid_i    (Valid_i),
    .Ready_o    (Ready_o),
    .Opc_i      (Opc_i),
    .DinA_i     (DinA_i),
    .DinB_i     (DinB_i),
    .Valid_o    (Valid_o),
    .Ready_i    (Ready_i),
    .Dout_o     (Dout_o),
    .OverFlow_o (OverFlow_o),
    .Zero_o     (Zero_o)
  );

  always #5 Clk_i = ~Clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic: {dout, overflow, zero}.
  function automatic logic [9:0] model(input int opc, input int a, input int b);
    int d, o, sa, sh;
    logic [7:0] dd;
    o  = 0;
    sh = b % 8;
    case (opc)
      0: begin d = a + b; o = (d > 255) ? 1 : 0; end
      1: begin d = a - b + 256; o = (a < b) ? 1 : 0; end
      2: d = a & b;
      3: d = a | b;
      4: d = a ^ b;
      5: d = a * (1 << sh);
      6: d = a / (1 << sh);
      default: begin
        sa = (a >= 128) ? a - 256 : a;
        d  = sa >>> sh;
      end
    endcase
    dd = d[7:0];
    return {dd, o[0], (dd == 8'd0)};
  endfunction

  // Compare process: every output beat is checked against the model queue.
  always @(negedge Clk_i) begin
    if (Reset_i) begin
      q.delete();
    end else begin
      if (Valid_o) begin
        if (q.size() == 0) begin
          chk("model_unexpected_beat", 32'd1, 32'd0);
        end else begin
          chk("model_payload", {22'd0, Dout_o, OverFlow_o, Zero_o}, {22'd0, q[0]});
          if (Ready_i) void'(q.pop_front());
        end
      end
      if (Valid_i && Ready_o)
        q.push_back(model(int'(Opc_i), int'(DinA_i), int'(DinB_i)));
    end
  end

  task automatic tick();
    @(posedge Clk_i);
    #1;
  endtask

  task automatic drive(input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b);
    Opc_i  = opc;
    DinA_i = a;
    DinB_i = b;
    Valid_i = 1'b1;
  endtask

  task automatic send_chk(input string name, input logic [2:0] opc, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] ed, input logic eo,
                          input logic ez);
    Ready_i = 1'b1;
    drive(opc, a, b);
    tick();
    Valid_i = 1'b0;
    tick();
    chk({name, "_valid"}, {31'd0, Valid_o}, 32'd1);
    chk({name, "_dout"}, {24'd0, Dout_o}, {24'd0, ed});
    chk({name, "_ovf"}, {31'd0, OverFlow_o}, {31'd0, eo});
    chk({name, "_zero"}, {31'd0, Zero_o}, {31'd0, ez});
  endtask

  task automatic idle(input int n);
    Valid_i = 1'b0;
    Ready_i = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [2:0]  t_opc [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd7, 3'd5};
  logic [7:0]  t_a   [12] = '{8'hFF, 8'h10, 8'hF0, 8'h0F, 8'hAA, 8'h01, 8'hFF, 8'h7F, 8'h00, 8'h00, 8'hC3, 8'h80};
  logic [7:0]  t_b   [12] = '{8'h01, 8'h20, 8'h3C, 8'hF0, 8'hAA, 8'h0F, 8'h07, 8'h02, 8'h00, 8'h01, 8'h0C, 8'h01};
  logic [15:0] rdy_pat = 16'b1011_0011_1100_1101;

  initial begin
    int k, guard;
    logic acc;

    // Reset state
    #2;
    chk("rst_valid", {31'd0, Valid_o}, 32'd0);
    chk("rst_dout", {24'd0, Dout_o}, 32'd0);
    chk("rst_ovf", {31'd0, OverFlow_o}, 32'd0);
    chk("rst_zero", {31'd0, Zero_o}, 32'd0);
    tick();
    Reset_i = 1'b0;
    #1;
    chk("rst_ready", {31'd0, Ready_o}, 32'd1);
    tick();

    // Directed arithmetic and shift vectors
    send_chk("add_ovf", OPC_ADD, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0);
    send_chk("sub_borrow", OPC_SUB, 8'd5, 8'd7, 8'd254, 1'b1, 1'b0);
    send_chk("sub_zero", OPC_SUB, 8'd9, 8'd9, 8'd0, 1'b0, 1'b1);
    send_chk("shl", OPC_SHL, 8'h81, 8'd9, 8'h02, 1'b0, 1'b0);
    send_chk("sra", OPC_SRA, 8'h80, 8'd3, 8'hF0, 1'b0, 1'b0);
    send_chk("shr", OPC_SHR, 8'h80, 8'd3, 8'h10, 1'b0, 1'b0);
    idle(3);
    chk("drained_valid", {31'd0, Valid_o}, 32'd0);

    // Backpressure: three XORs into a stalled pipe
    Ready_i = 1'b0;
    drive(OPC_XOR, 8'hFF, 8'd1);
    tick();
    chk("bp_ready_one", {31'd0, Ready_o}, 32'd1);
    DinB_i = 8'd2;
    tick();
    chk("bp_ready_full", {31'd0, Ready_o}, 32'd0);
    DinB_i = 8'd3;
    tick();
    chk("bp_ready_held", {31'd0, Ready_o}, 32'd0);
    chk("bp_hold_valid", {31'd0, Valid_o}, 32'd1);
    chk("bp_hold_dout", {24'd0, Dout_o}, 32'h0FE);
    Ready_i = 1'b1;
    #1;
    chk("bp_ready_comb", {31'd0, Ready_o}, 32'd1);
    tick();
    Valid_i = 1'b0;
    chk("bp_out2", {24'd0, Dout_o}, 32'h0FD);
    tick();
    chk("bp_out3", {24'd0, Dout_o}, 32'h0FC);
    tick();
    chk("bp_empty", {31'd0, Valid_o}, 32'd0);

    // Bubble collapse: output stalled, slice 0 empty
    Ready_i = 1'b0;
    drive(OPC_OR, 8'h0F, 8'hF0);
    tick();
    Valid_i = 1'b0;
    tick();
    chk("bub_valid", {31'd0, Valid_o}, 32'd1);
    chk("bub_ready", {31'd0, Ready_o}, 32'd1);
    drive(OPC_AND, 8'h0F, 8'hF0);
    tick();
    Valid_i = 1'b0;
    chk("bub_filled", {31'd0, Ready_o}, 32'd0);
    chk("bub_hold_dout", {24'd0, Dout_o}, 32'h0FF);
    idle(3);

    // Reset with two results in flight
    Ready_i = 1'b0;
    drive(OPC_ADD, 8'd3, 8'd4);
    tick();
    tick();
    Valid_i = 1'b0;
    chk("mr_full_valid", {31'd0, Valid_o}, 32'd1);
    #2;
    Reset_i = 1'b1;
    #1;
    chk("mr_valid", {31'd0, Valid_o}, 32'd0);
    chk("mr_dout", {24'd0, Dout_o}, 32'd0);
    chk("mr_ovf", {31'd0, OverFlow_o}, 32'd0);
    chk("mr_zero", {31'd0, Zero_o}, 32'd0);
    tick();
    Reset_i = 1'b0;
    #1;
    chk("mr_ready", {31'd0, Ready_o}, 32'd1);
    send_chk("mr_add", OPC_ADD, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0);
    idle(3);

    // Mixed stream with a fixed stall pattern, checked by the model
    k = 0;
    for (int i = 0; i < 12; i++) begin
      drive(t_opc[i], t_a[i], t_b[i]);
      guard = 0;
      do begin
        Ready_i = rdy_pat[k % 16];
        k++;
        #1;
        acc = Ready_o;
        tick();
        guard++;
      end while (!acc && guard < 20);
      if (!acc) chk("stream_accept_timeout", 32'd0, 32'd1);
    end
    Valid_i = 1'b0;
    Ready_i = 1'b1;
    guard = 0;
    while ((q.size() != 0 || Valid_o) && guard < 20) begin
      tick();
      guard++;
    end
    #5;
    chk("stream_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
